ball_query_collector: RTL and testbench
=======================================

Name: ball_query_collector

Overview:
- Sits directly downstream of the squared-distance (EDC) stage in the grouping pipeline.
- Takes the stream of (point index, 18-bit squared distance) pairs for one centre point and keeps the indices whose distance is within the squared radius, up to NSAMPLE of them, first-come order.
- Pads the group to exactly NSAMPLE entries and streams the group indices to the gather stage over a valid/ready handshake.

Parameters:
- IDX_W, 10, width of a point index.
- NSAMPLE, 16, group size (number of indices emitted per centre); must be >= 2.
- CNT_W, 5, width of found_cnt; must satisfy 2^CNT_W > NSAMPLE.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins one query; honoured only in IDLE.
- radius_sq  input  18  squared radius; sampled on an accepted start.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  block accepts a pair.
- in_idx  input  IDX_W  point index.
- in_dist  input  18  squared distance from the EDC stage (max 195075).
- in_last  input  1  marks the final pair of the point stream.
- out_valid  output  1  group index valid.
- out_ready  input  1  downstream accepts.
- out_idx  output  IDX_W  group index.
- out_last  output  1  marks the NSAMPLE-th (final) group index.
- found_cnt  output  CNT_W  true hit count, saturated at NSAMPLE.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 (in_ready, out_valid, out_idx, out_last, found_cnt, busy, done); write pointer, read pointer and radius register cleared. Buffer contents need not be cleared.
- Reset mid-operation aborts the query immediately. No partial output is emitted afterwards.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 latches radius_sq into radius_r, clears the hit count and pointers, and moves to SCAN next cycle.
- State SCAN:
  - in_ready=1 every cycle; a pair is accepted when in_valid&in_ready.
  - hit = (in_dist <= radius_r), unsigned, inclusive.
  - Hit with hit count < NSAMPLE: buf[hit count] <= in_idx; hit count increments.
  - Hit with hit count == NSAMPLE: index dropped, but the pair is still consumed. The full upstream stream is always drained.
  - Accepted pair with in_last=1: evaluated as above (a hit on the last pair is counted); move to PAD next cycle.
  - in_valid=0 stalls SCAN indefinitely.
- State PAD:
  - found_cnt <= hit count on entry; held until the next accepted start.
  - Write pointer wp starts at the hit count.
  - Each cycle with wp < NSAMPLE: buf[wp] <= (hit count>0 ? buf[0] : 0), then wp++.
  - When wp == NSAMPLE, move to OUT next cycle.
  - Duration is max(1, NSAMPLE - hits) cycles.
- State OUT:
  - out_valid=1; out_idx=buf[rp]; out_last=(rp==NSAMPLE-1).
  - out_idx and out_last are held stable while out_valid&!out_ready.
  - On a handshake, rp++.
  - On the handshake with out_last=1: done=1 in the next cycle, state=IDLE, out_valid=0 in that cycle.
- start outside IDLE is ignored, including start in the same cycle as the final handshake.
- in_valid outside SCAN is ignored; in_ready stays 0 there.
- Latency:
  - First out_valid is asserted max(1, NSAMPLE-hits)+1 cycles after the cycle in which in_last is accepted.
  - With out_ready held high, one index is emitted per cycle.

Test Plan (NSAMPLE=4 override unless stated):
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, pulse start, radius_sq=100 -> busy=1, in_ready=1 one cycle later.
- Saturation: radius_sq=100; idx 0..7 with dist 50,200,100,101,0,300,99,7, last on idx7 -> found_cnt=4; out_idx 0,2,4,6 with out_last on 6; all 8 pairs consumed; done pulses once.
- Partial pad: hits only at idx 3 (dist 10) and idx 5 (dist 100 == radius) -> found_cnt=2; PAD lasts 2 cycles; out_idx 3,5,3,3.
- Empty: radius_sq=0, all dist >= 1 -> found_cnt=0; out_idx 0,0,0,0.
- Boundary/backpressure, default NSAMPLE=16: radius_sq=195075, one pair dist=195075 with in_last -> hit. found_cnt=1; PAD 15 cycles; 16 outputs all equal to that index. Hold out_ready=0 for 3 cycles mid-stream -> out_idx/out_last unchanged.
- Reset mid-SCAN after 2 hits -> outputs 0 immediately. A new start with fresh data yields only the new hits; nothing from the aborted query appears.

Source files
------------

// File: rtl/ball_query_collector.sv
// ball_query_collector
//
// Collects the neighbour indices for one centre point in the grouping pipeline.
// It sits directly behind the squared-distance (EDC) stage. For each incoming
// (index, squared distance) pair it keeps the index when the distance is within
// the squared radius, in arrival order. It keeps at most NSAMPLE indices.
// It then pads the group to exactly NSAMPLE entries and streams the group out.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start, radius_sq  one-cycle query start; radius latched on an accepted start
//   in_valid/in_ready pair handshake from the EDC stage
//   in_idx, in_dist   point index and its 18-bit squared distance
//   in_last           final pair of the point stream
//   out_valid/out_ready group-index handshake towards the gather stage
//   out_idx, out_last group index; out_last flags the NSAMPLE-th entry
//   found_cnt         true hit count, saturated at NSAMPLE, held until next start
//   busy, done        not-idle flag; one-cycle pulse after the final output
module ball_query_collector #(
    parameter int IDX_W   = 10,
    parameter int NSAMPLE = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [17:0]      radius_sq,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [17:0]      in_dist,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [CNT_W-1:0] found_cnt,
    output logic             busy,
    output logic             done
);

    localparam int AW = (NSAMPLE > 1) ? $clog2(NSAMPLE) : 1;
    localparam logic [CNT_W-1:0] N_C    = CNT_W'(NSAMPLE);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NSAMPLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_PAD,
        ST_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [17:0]      radius_q, radius_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // hits stored so far (SCAN write pointer)
    logic [CNT_W-1:0] wp_q, wp_d;        // padding write pointer
    logic [CNT_W-1:0] rp_q, rp_d;        // output read pointer
    logic [CNT_W-1:0] found_q, found_d;
    logic             done_q, done_d;

    // Group buffer. It has no reset: every entry that is read out was written
    // earlier in the same query, either during SCAN or during PAD.
    logic [IDX_W-1:0] grp_buf_q [NSAMPLE];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [IDX_W-1:0] wr_data;

    logic hit;

    assign hit = (in_dist <= radius_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            radius_q <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            found_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            radius_q <= radius_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            found_q  <= found_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            grp_buf_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        radius_d = radius_q;
        cnt_d    = cnt_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        found_d  = found_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = cnt_q[AW-1:0];
        wr_data  = in_idx;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    radius_d = radius_sq;
                    cnt_d    = '0;
                    wp_d     = '0;
                    rp_d     = '0;
                    found_d  = '0;
                    state_d  = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (in_valid) begin
                    // Hits beyond NSAMPLE are dropped, but the pair is still
                    // consumed so that the upstream stream always drains.
                    if (hit && (cnt_q < N_C)) begin
                        wr_en   = 1'b1;
                        wr_addr = cnt_q[AW-1:0];
                        wr_data = in_idx;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        // cnt_d includes a hit on the last pair.
                        wp_d    = cnt_d;
                        found_d = cnt_d;
                        state_d = ST_PAD;
                    end
                end
            end

            ST_PAD: begin
                // Each free slot is filled with the first hit, or with 0 when
                // there were no hits. A full group still spends one cycle here.
                if (wp_q < N_C) begin
                    wr_en   = 1'b1;
                    wr_addr = wp_q[AW-1:0];
                    wr_data = (cnt_q != '0) ? grp_buf_q[0] : '0;
                    wp_d    = wp_q + CNT_W'(1);
                    if (wp_q == LAST_C) begin
                        state_d = ST_OUT;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    if (rp_q == LAST_C) begin
                        rp_d    = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rp_d = rp_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The outputs depend only on registers, so they stay stable under backpressure.
    // They are forced to zero outside OUT, and therefore also during reset.
    assign in_ready  = (state_q == ST_SCAN);
    assign out_valid = (state_q == ST_OUT);
    assign out_idx   = (state_q == ST_OUT) ? grp_buf_q[rp_q[AW-1:0]] : '0;
    assign out_last  = (state_q == ST_OUT) && (rp_q == LAST_C);
    assign found_cnt = found_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_ball_query_collector.sv
// Directed bench for ball_query_collector. It uses one instance with NSAMPLE=4
// and one instance with the default NSAMPLE=16. The expected group indices come
// from a small model. The model pushes them into a queue while the pairs are
// driven. The bench pops one expected index for each output handshake.
module tb_ball_query_collector;

    localparam int IDX_W = 10;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start4, start16;
    logic [17:0]      radius_sq;
    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    logic [17:0]      in_dist;
    logic             in_last;
    logic             out_ready;

    logic             in_ready4, out_valid4, out_last4, busy4, done4;
    logic [IDX_W-1:0] out_idx4;
    logic [CNT_W-1:0] found4;
    logic             in_ready16, out_valid16, out_last16, busy16, done16;
    logic [IDX_W-1:0] out_idx16;
    logic [CNT_W-1:0] found16;

    ball_query_collector #(.IDX_W(IDX_W), .NSAMPLE(4), .CNT_W(CNT_W)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .radius_sq (radius_sq),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_idx    (in_idx),
        .in_dist   (in_dist),
        .in_last   (in_last),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_idx   (out_idx4),
        .out_last  (out_last4),
        .found_cnt (found4),
        .busy      (busy4),
        .done      (done4)
    );

    ball_query_collector #(.IDX_W(IDX_W), .NSAMPLE(16), .CNT_W(CNT_W)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start16),
        .radius_sq (radius_sq),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .in_idx    (in_idx),
        .in_dist   (in_dist),
        .in_last   (in_last),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .out_idx   (out_idx16),
        .out_last  (out_last16),
        .found_cnt (found16),
        .busy      (busy16),
        .done      (done16)
    );

    // Outputs of the instance selected for the current query.
    bit               use16;
    logic             m_in_ready, m_out_valid, m_out_last, m_busy, m_done;
    logic [IDX_W-1:0] m_out_idx;
    logic [CNT_W-1:0] m_found;
    assign m_in_ready  = use16 ? in_ready16  : in_ready4;
    assign m_out_valid = use16 ? out_valid16 : out_valid4;
    assign m_out_last  = use16 ? out_last16  : out_last4;
    assign m_busy      = use16 ? busy16      : busy4;
    assign m_done      = use16 ? done16      : done4;
    assign m_out_idx   = use16 ? out_idx16   : out_idx4;
    assign m_found     = use16 ? found16     : found4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IDX_W-1:0] exp_q[$];
    logic [IDX_W-1:0] sidx[$];
    logic [17:0]      sdist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_start(input bit sel, input logic [17:0] r);
        use16 = sel;
        @(negedge clk);
        if (sel) start16 = 1'b1; else start4 = 1'b1;
        radius_sq = r;
        @(negedge clk);
        start4  = 1'b0;
        start16 = 1'b0;
        check("busy_after_start", m_busy, 1);
        check("in_ready_after_start", m_in_ready, 1);
    endtask

    // Sends sidx/sdist as one stream and builds the expected group. Then it
    // collects NSAMPLE outputs and stalls for stall_len cycles once stall_at
    // indices have been emitted.
    task automatic run_query(input bit sel, input logic [17:0] r,
                             input int stall_at, input int stall_len);
        int n;
        int hits;
        int k;
        int emitted;
        int stalled;
        bit first_seen;
        bit fin;
        logic [IDX_W-1:0] first_hit;
        logic [IDX_W-1:0] e;
        n = sel ? 16 : 4;
        hits = 0;
        emitted = 0;
        stalled = 0;
        first_seen = 1'b0;
        fin = 1'b0;
        first_hit = '0;
        exp_q.delete();
        do_start(sel, r);
        for (int i = 0; i < sidx.size(); i++) begin
            in_valid = 1'b1;
            in_idx   = sidx[i];
            in_dist  = sdist[i];
            in_last  = (i == sidx.size() - 1);
            check("pair_accepted", m_in_ready, 1);
            if (sdist[i] <= r && hits < n) begin
                if (hits == 0) first_hit = sidx[i];
                exp_q.push_back(sidx[i]);
                hits++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_ready_after_last", m_in_ready, 0);
        while (exp_q.size() < n) exp_q.push_back(hits > 0 ? first_hit : '0);
        k = (n - hits > 1) ? (n - hits) : 1;
        for (int c = 1; c <= 400 && !fin; c++) begin
            out_ready = 1'b1;
            if (m_out_valid) begin
                if (!first_seen) begin
                    check("first_valid_latency", c, k + 1);
                    first_seen = 1'b1;
                end
                if (emitted == stall_at && stalled < stall_len) begin
                    out_ready = 1'b0;
                    check("stall_out_idx", m_out_idx, exp_q[0]);
                    check("stall_out_last", m_out_last, exp_q.size() == 1);
                    stalled++;
                end else begin
                    e = exp_q.pop_front();
                    $display("out[%0d] idx=%0d last=%0d (expected idx=%0d)",
                             emitted, m_out_idx, m_out_last, e);
                    check("out_idx", m_out_idx, e);
                    check("out_last", m_out_last, exp_q.size() == 0);
                    emitted++;
                    if (exp_q.size() == 0) fin = 1'b1;
                end
            end
            @(negedge clk);
        end
        check("collect_complete", fin, 1);
        check("done_pulse", m_done, 1);
        check("out_valid_after_last", m_out_valid, 0);
        check("busy_after_last", m_busy, 0);
        check("found_cnt", m_found, hits);
        @(negedge clk);
        check("done_single_cycle", m_done, 0);
        check("found_cnt_held", m_found, hits);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  {in_ready4, in_ready16}, 0);
        check({tag, "_out_valid"}, {out_valid4, out_valid16}, 0);
        check({tag, "_out_idx"},   {out_idx4, out_idx16}, 0);
        check({tag, "_out_last"},  {out_last4, out_last16}, 0);
        check({tag, "_found_cnt"}, {found4, found16}, 0);
        check({tag, "_busy"},      {busy4, busy16}, 0);
        check({tag, "_done"},      {done4, done16}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        use16 = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start4    = 1'($urandom);
            start16   = 1'($urandom);
            radius_sq = 18'($urandom);
            in_valid  = 1'($urandom);
            in_idx    = 10'($urandom);
            in_dist   = 18'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            #1 check_all_zero("reset");
        end
        @(negedge clk);
        start4 = 1'b0; start16 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;

        // Saturation: the 8th pair hits but is dropped.
        sidx  = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
        sdist = '{18'd50, 18'd200, 18'd100, 18'd101, 18'd0, 18'd300, 18'd99, 18'd7};
        run_query(1'b0, 18'd100, -1, 0);

        // Partial pad: dist equal to the radius is a hit.
        sidx  = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};
        sdist = '{18'd200, 18'd150, 18'd101, 18'd10, 18'd500, 18'd100, 18'd101};
        run_query(1'b0, 18'd100, -1, 0);

        // Empty group.
        sidx  = '{10'd9, 10'd10, 10'd11, 10'd12};
        sdist = '{18'd1, 18'd5, 18'd195075, 18'd3};
        run_query(1'b0, 18'd0, -1, 0);

        // Maximum distance at NSAMPLE=16, with a 3-cycle stall mid-stream.
        sidx  = '{10'd677};
        sdist = '{18'd195075};
        run_query(1'b1, 18'd195075, 5, 3);

        // Reset mid-SCAN after two hits.
        do_start(1'b0, 18'd100);
        in_valid = 1'b1; in_idx = 10'd1; in_dist = 18'd5; in_last = 1'b0;
        @(negedge clk);
        in_idx = 10'd2; in_dist = 18'd6;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        sidx  = '{10'd20, 10'd21, 10'd22, 10'd23, 10'd24};
        sdist = '{18'd60, 18'd50, 18'd0, 18'd51, 18'd49};
        run_query(1'b0, 18'd50, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
